preg_fre_lst: RTL
=================

Name: preg_fre_lst

Overview:
- Physical-register free-list controller for the rename stage; supplies the pdst field loaded into each issue-queue line.
- Holds free physical register indices in a circular FIFO of 64 entries.
- Grants up to two allocations per cycle (dual dispatch) and accepts up to two returned registers per cycle, in the same {vld, idx} format the rename lines emit on fre_preg.
- Supports one head checkpoint with flush recovery.

Parameters:
- PREG_NUM, 64, number of physical registers; also the FIFO depth.
- PREG_BITS, 6, width of a physical register index.
- ARCH_REGS, 16, physical regs 0..ARCH_REGS-1 hold the initial architectural mapping and are never initially free.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- alloc_req  in  2  bit0: dispatch slot0 needs a pdst; bit1: slot1 needs one.
- alloc_gnt  out  1  all requested slots served this cycle (combinational).
- alloc_preg0  out  6  pdst for slot0; valid when alloc_gnt & alloc_req[0].
- alloc_preg1  out  6  pdst for slot1; valid when alloc_gnt & alloc_req[1].
- fre_preg0  in  7  {vld, idx[5:0]} returned register, port 0.
- fre_preg1  in  7  {vld, idx[5:0]} returned register, port 1.
- ckpt_save  in  1  record the current head pointer as the checkpoint.
- flush  in  1  restore the head pointer to the checkpoint (mispredict recovery).
- fl_cnt  out  7  free entries, 0..64 (registered).
- fl_rdy  out  1  initialisation complete (registered).
- fl_err  out  1  sticky error flag (registered).

Behaviour:
- State: mem[0:63] of 6-bit entries (no reset), head[5:0], tail[5:0], cnt[6:0], ckpt[5:0], FSM {INIT, RUN}. Pointers wrap modulo 64.
- Reset (rst=1 at an edge): FSM=INIT, head=tail=cnt=ckpt=0, fl_rdy=0, fl_err=0. alloc_gnt=0 whenever FSM is not RUN.
- INIT:
  - Each cycle, mem[tail] <= ARCH_REGS + tail; tail and cnt increment.
  - After 48 writes (tail=48, cnt=48), FSM goes to RUN and fl_rdy=1 on the following cycle. Reset-to-ready latency is 48 cycles.
  - In INIT, any valid free, alloc_req != 0, or flush sets fl_err and is ignored.
- RUN allocation:
  - n_req = popcount(alloc_req).
  - alloc_gnt = (n_req != 0) & (n_req <= cnt) & !flush. All-or-nothing; never a partial grant.
  - alloc_preg0 = mem[head]; alloc_preg1 = mem[head + alloc_req[0]]. Slot1 alone takes the head entry.
  - On grant: head += n_req.
- RUN free:
  - Each valid port writes to the tail in port order: port0 to tail, port1 to tail+1 if port0 is valid, else to tail.
  - tail += n_fre.
  - Frees are not visible to a grant in the same cycle; the grant uses the old cnt.
  - If cnt - granted + n_fre > 64: set fl_err and drop the excess frees (port1 first). tail and cnt advance only by the accepted frees.
- cnt update: cnt_next = cnt - (alloc_gnt ? n_req : 0) + accepted frees.
- Checkpoint and flush:
  - ckpt_save (no flush): ckpt <= head after this cycle's grant is applied.
  - flush:
    - No grant this cycle.
    - head <= ckpt.
    - cnt <= cnt + ((head - ckpt) mod 64) + accepted frees.
    - Frees in the same cycle are still appended.
    - ckpt_save with flush is ignored; ckpt is unchanged.
- fl_cnt mirrors cnt. fl_err is cleared only by rst.
- Reset asserted mid-operation aborts everything and restarts INIT; mem contents are rewritten.

Test Plan:
- Reset release -> fl_rdy=0 for 48 cycles, then fl_rdy=1, fl_cnt=48, alloc_preg0=16 with alloc_req=2'b01.
- alloc_req=2'b11 for 3 cycles -> grants return (16,17), (18,19), (20,21); fl_cnt=42. A following alloc_req=2'b10 -> alloc_preg1=22.
- Drain to fl_cnt=1, then alloc_req=2'b11 -> alloc_gnt=0, head unchanged. alloc_req=2'b01 -> grant 63, fl_cnt=0.
- fl_cnt=0, alloc_req=2'b01 with fre_preg0={1,6'd5} same cycle -> alloc_gnt=0 that cycle; next cycle grant returns 5.
- ckpt_save at head=4, then 3 single grants (head=7, fl_cnt=45), then flush with fre_preg1={1,6'd3} -> head=4, fl_cnt=49, alloc_gnt=0 during the flush cycle. Next allocation returns 20.
- fl_cnt=64 plus a valid fre_preg0 -> fl_err=1 (sticky), fl_cnt stays 64. A valid free during INIT -> fl_err=1.

Source files
------------

// File: rtl/preg_fre_lst.sv
// Physical-register free list for the rename stage: a 64-entry circular FIFO of
// free pdst indices with dual allocate, dual return and one head checkpoint.
module preg_fre_lst #(
    parameter int PREG_NUM  = 64,
    parameter int PREG_BITS = 6,
    parameter int ARCH_REGS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           alloc_req,
    output logic                 alloc_gnt,
    output logic [PREG_BITS-1:0] alloc_preg0,
    output logic [PREG_BITS-1:0] alloc_preg1,
    input  logic [PREG_BITS:0]   fre_preg0,
    input  logic [PREG_BITS:0]   fre_preg1,
    input  logic                 ckpt_save,
    input  logic                 flush,
    output logic [PREG_BITS:0]   fl_cnt,
    output logic                 fl_rdy,
    output logic                 fl_err
);

    localparam int CNT_BITS = PREG_BITS + 1;
    localparam int BASE_BITS = PREG_BITS + 2;
    localparam logic [BASE_BITS-1:0] FULL = BASE_BITS'(PREG_NUM);
    localparam logic [CNT_BITS-1:0] INIT_LAST = CNT_BITS'(PREG_NUM - ARCH_REGS - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t               state;
    logic [PREG_BITS-1:0] mem [PREG_NUM];
    logic [PREG_BITS-1:0] head;
    logic [PREG_BITS-1:0] tail;
    logic [PREG_BITS-1:0] ckpt;
    logic [CNT_BITS-1:0]  cnt;

    logic [1:0]           n_req;
    logic [1:0]           n_acc;
    logic                 acc0;
    logic                 acc1;
    logic                 drop;
    logic [BASE_BITS-1:0] base;
    logic [PREG_BITS-1:0] head_next;
    logic [CNT_BITS-1:0]  cnt_next;
    logic                 wr0_en;
    logic                 wr1_en;
    logic [PREG_BITS-1:0] wr0_addr;
    logic [PREG_BITS-1:0] wr1_addr;
    logic [PREG_BITS-1:0] wr0_data;
    logic                 init_act;

    always_comb begin
        n_req     = {1'b0, alloc_req[0]} + {1'b0, alloc_req[1]};
        alloc_gnt = (state == RUN) && (n_req != 2'd0) &&
                    (CNT_BITS'(n_req) <= cnt) && !flush;
        alloc_preg0 = mem[head];
        alloc_preg1 = mem[head + PREG_BITS'(alloc_req[0])];

        // Occupancy the frees are checked against: post-grant, or post-restore on flush.
        if (flush)
            base = BASE_BITS'(cnt) + BASE_BITS'(head - ckpt);
        else
            base = BASE_BITS'(cnt) - (alloc_gnt ? BASE_BITS'(n_req) : '0);

        acc0  = fre_preg0[PREG_BITS] && (base < FULL);
        acc1  = fre_preg1[PREG_BITS] && ((base + BASE_BITS'(acc0)) < FULL);
        drop  = (fre_preg0[PREG_BITS] && !acc0) || (fre_preg1[PREG_BITS] && !acc1);
        n_acc = {1'b0, acc0} + {1'b0, acc1};

        cnt_next  = CNT_BITS'(base + BASE_BITS'(n_acc));
        head_next = flush ? ckpt : head + (alloc_gnt ? PREG_BITS'(n_req) : '0);

        init_act = fre_preg0[PREG_BITS] || fre_preg1[PREG_BITS] ||
                   (alloc_req != 2'b00) || flush;

        wr0_en   = '0;
        wr1_en   = '0;
        wr0_addr = tail;
        wr1_addr = tail + PREG_BITS'(acc0);
        wr0_data = fre_preg0[PREG_BITS-1:0];
        if (!rst) begin
            if (state == INIT) begin
                wr0_en   = 1'b1;
                wr0_data = PREG_BITS'(ARCH_REGS) + tail;
            end else begin
                wr0_en = acc0;
                wr1_en = acc1;
            end
        end
    end

    assign fl_cnt = cnt;

    always_ff @(posedge clk) begin
        if (wr0_en)
            mem[wr0_addr] <= wr0_data;
        if (wr1_en)
            mem[wr1_addr] <= fre_preg1[PREG_BITS-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= INIT;
            head   <= '0;
            tail   <= '0;
            ckpt   <= '0;
            cnt    <= '0;
            fl_rdy <= 1'b0;
            fl_err <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    tail <= tail + 1'b1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == INIT_LAST) begin
                        state  <= RUN;
                        fl_rdy <= 1'b1;
                    end
                    if (init_act)
                        fl_err <= 1'b1;
                end
                RUN: begin
                    head <= head_next;
                    tail <= tail + PREG_BITS'(n_acc);
                    cnt  <= cnt_next;
                    if (ckpt_save && !flush)
                        ckpt <= head_next;
                    if (drop)
                        fl_err <= 1'b1;
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule
